// File: rtl/bubble_sort_seq.sv
// bubble_sort_seq: sequential bubble-sort engine with a single comparator.
//   Loads N unsigned W-bit words over a valid/ready input stream, sorts them
//   in place (one adjacent compare-and-swap per clock, early exit after the
//   first clean pass), then returns them smallest-first over a valid/ready
//   output stream.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data holds a valid element
//   in_ready   engine accepts an element this cycle (LOAD only)
//   in_data    element to load
//   out_valid  out_data holds a valid sorted element (DRAIN only)
//   out_ready  consumer accepts out_data this cycle
//   out_data   sorted element, smallest first; zero outside DRAIN
//   busy       high while sorting
//   passes     passes executed for the current/last batch
module bubble_sort_seq #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int PW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic [PW-1:0] passes
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t r_state, w_state_nxt;

  logic [W-1:0]  r_mem [N];
  logic [IW-1:0] r_wr, r_rd, r_i;
  logic          r_swapped;
  logic [PW-1:0] r_passes;

  logic [IW-1:0] w_i_p1;
  logic [W-1:0]  w_left, w_right;
  logic          w_gt, w_pass_end, w_resort;
  logic          w_in_xfer, w_out_xfer, w_load_last, w_drain_last;

  assign w_i_p1       = r_i + IW'(1);
  assign w_left       = r_mem[r_i];
  assign w_right      = r_mem[w_i_p1];
  // Strict compare: equal neighbours stay put, which keeps the sort stable.
  assign w_gt         = (w_left > w_right);
  assign w_pass_end   = (r_i == IW'(N - 2));
  assign w_resort     = r_swapped | w_gt;
  assign w_in_xfer    = (r_state == LOAD) && in_valid;
  assign w_out_xfer   = (r_state == DRAIN) && out_ready;
  assign w_load_last  = w_in_xfer && (r_wr == IW'(N - 1));
  assign w_drain_last = w_out_xfer && (r_rd == IW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LOAD:    if (w_load_last) w_state_nxt = SORT;
      SORT:    if (w_pass_end && !w_resort) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_last) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // Output logic: handshake flags depend on state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    unique case (r_state)
      LOAD:  in_ready = 1'b1;
      SORT:  busy     = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_mem[r_rd];
      end
      default: ;
    endcase
  end

  assign passes = r_passes;

  // Index / pass bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_i       <= '0;
      r_swapped <= 1'b0;
      r_passes  <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (w_load_last) begin
            r_wr      <= '0;
            r_i       <= '0;
            r_swapped <= 1'b0;
            r_passes  <= '0;
          end else if (w_in_xfer) begin
            r_wr <= r_wr + IW'(1);
          end
        end
        SORT: begin
          if (w_pass_end) begin
            r_passes <= r_passes + PW'(1);
            // A swap on the final compare of a pass still forces another pass.
            if (w_resort) begin
              r_i       <= '0;
              r_swapped <= 1'b0;
            end else begin
              r_rd <= '0;
            end
          end else begin
            r_i <= w_i_p1;
            if (w_gt) r_swapped <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_drain_last) begin
            r_rd <= '0;
            r_wr <= '0;
          end else if (w_out_xfer) begin
            r_rd <= r_rd + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage array: not reset, only ever read after a full load
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_mem[r_wr] <= in_data;
    end else if ((r_state == SORT) && w_gt) begin
      r_mem[r_i]    <= w_right;
      r_mem[w_i_p1] <= w_left;
    end
  end

endmodule

// File: tb/tb_bubble_sort_seq.sv
// tb_bubble_sort_seq: self-checking bench for bubble_sort_seq (N=8 and N=2
//   instances). Expected order comes from a queue sort; expected pass count
//   comes from the largest number of greater elements preceding any element.
module tb_bubble_sort_seq;

  logic       clk, reset, in_valid, out_ready, sel;
  logic [7:0] in_data;

  logic       ir8, ov8, bz8, ir2, ov2, bz2;
  logic [7:0] od8, od2;
  logic [3:0] p8;
  logic [1:0] p2;

  logic       o_in_ready, o_out_valid, o_busy;
  logic [7:0] o_out_data, o_passes;

  int n_checks = 0;
  int n_errors = 0;

  bubble_sort_seq #(.N(8), .W(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & ~sel), .in_ready(ir8), .in_data(in_data),
    .out_valid(ov8), .out_ready(out_ready & ~sel), .out_data(od8),
    .busy(bz8), .passes(p8)
  );

  bubble_sort_seq #(.N(2), .W(8)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & sel), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready & sel), .out_data(od2),
    .busy(bz2), .passes(p2)
  );

  assign o_in_ready  = sel ? ir2 : ir8;
  assign o_out_valid = sel ? ov2 : ov8;
  assign o_busy      = sel ? bz2 : bz8;
  assign o_out_data  = sel ? od2 : od8;
  assign o_passes    = sel ? 8'(p2) : 8'(p8);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ascending order plus bubble-sort pass count.
  task automatic model(input int n, input logic [7:0] d[8],
                       output logic [7:0] s[8], output int p);
    int q[$];
    int maxinv = 0;
    for (int j = 0; j < 8; j++) s[j] = 8'd0;
    for (int j = 0; j < n; j++) begin
      int c = 0;
      q.push_back(int'(d[j]));
      for (int k = 0; k < j; k++) if (d[k] > d[j]) c++;
      if (c > maxinv) maxinv = c;
    end
    q.sort();
    for (int j = 0; j < n; j++) s[j] = 8'(q[j]);
    p = maxinv + 1;
  endtask

  // Drives one batch through load / sort / drain; reports what it saw.
  task automatic run_batch(input int n, input logic [7:0] d[8],
                           input int gap_pct, input int stall_pct,
                           output logic [7:0] got[8], output int sort_cyc,
                           output int drain_cyc, output int passes_seen,
                           output int viol, output bit tmo);
    int   loaded = 0, k = 0, guard = 0;
    bit   hold = 0;
    logic [7:0] held = 8'd0;
    viol = 0; tmo = 0; sort_cyc = 0; drain_cyc = 0; passes_seen = 0;
    for (int j = 0; j < 8; j++) got[j] = 8'd0;
    while (loaded < n && !tmo) begin
      in_valid  = ($urandom_range(99) >= gap_pct);
      in_data   = d[loaded];
      out_ready = 1'($urandom_range(1));
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_busy !== 1'b0 ||
          o_out_data !== 8'd0) viol++;
      if (in_valid && o_in_ready) loaded++;
      step();
      if (++guard > 2000) tmo = 1;
    end
    while (o_busy === 1'b1 && !tmo) begin
      in_valid  = 1'($urandom_range(1));
      in_data   = 8'($urandom_range(255));
      out_ready = 1'($urandom_range(1));
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_data !== 8'd0) viol++;
      sort_cyc++;
      step();
      if (++guard > 2000) tmo = 1;
    end
    passes_seen = int'(o_passes);
    while (k < n && !tmo) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      in_valid  = 1'($urandom_range(1));
      in_data   = 8'($urandom_range(255));
      if (o_in_ready !== 1'b0 || o_busy !== 1'b0) viol++;
      if (o_out_valid === 1'b1) begin
        drain_cyc++;
        if (hold && o_out_data !== held) viol++;
        if (int'(o_passes) != passes_seen) viol++;
        if (out_ready) begin
          got[k] = o_out_data;
          k++;
          hold = 0;
        end else begin
          hold = 1;
          held = o_out_data;
        end
      end else begin
        viol++;
      end
      step();
      if (++guard > 2000) tmo = 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) viol++;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; in_data = 0; sel = 0;
    reset = 1;
    step(); step();
    n_checks++;
    if ({ir8, ov8, bz8, od8, p8} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      n_errors++;
      $display("FAIL reset_n8: got ir=%b ov=%b busy=%b od=%0d passes=%0d, want 1 0 0 0 0",
               ir8, ov8, bz8, od8, p8);
    end
    n_checks++;
    if ({ir2, ov2, bz2, od2, p2} !== {1'b1, 1'b0, 1'b0, 8'd0, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_n2: got ir=%b ov=%b busy=%b od=%0d passes=%0d, want 1 0 0 0 0",
               ir2, ov2, bz2, od2, p2);
    end
    reset = 0;
    step();
  endtask

  // Runs a directed batch and checks all observable results against the model.
  task automatic test_directed(input string nm, input int n, input logic [7:0] d[8],
                               input int gap, input int stall, input bit full_rate);
    logic [7:0] got[8], exp_s[8];
    int sc, dc, ps, viol, exp_p;
    bit tmo;
    model(n, d, exp_s, exp_p);
    run_batch(n, d, gap, stall, got, sc, dc, ps, viol, tmo);
    n_checks++;
    if (tmo) begin
      n_errors++;
      $display("FAIL %s_timeout: batch did not complete within cycle budget", nm);
    end
    for (int j = 0; j < n; j++) begin
      n_checks++;
      if (got[j] !== exp_s[j]) begin
        n_errors++;
        $display("FAIL %s_data[%0d]: got %0d want %0d", nm, j, got[j], exp_s[j]);
      end
    end
    n_checks++;
    if (ps != exp_p) begin
      n_errors++;
      $display("FAIL %s_passes: got %0d want %0d", nm, ps, exp_p);
    end
    n_checks++;
    if (sc != exp_p * (n - 1)) begin
      n_errors++;
      $display("FAIL %s_sort_cycles: got %0d want %0d", nm, sc, exp_p * (n - 1));
    end
    n_checks++;
    if (viol != 0) begin
      n_errors++;
      $display("FAIL %s_protocol: got %0d violations want 0", nm, viol);
    end
    if (full_rate) begin
      n_checks++;
      if (dc != n) begin
        n_errors++;
        $display("FAIL %s_drain_cycles: got %0d want %0d", nm, dc, n);
      end
    end
  endtask

  task automatic test_sorted();
    logic [7:0] d[8];
    d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    sel = 0;
    test_directed("sorted", 8, d, 0, 0, 1);
  endtask

  task automatic test_reverse();
    logic [7:0] d[8];
    d = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    sel = 0;
    test_directed("reverse", 8, d, 0, 0, 1);
  endtask

  task automatic test_mixed();
    logic [7:0] d[8];
    d = '{8'd5, 8'd3, 8'd5, 8'd0, 8'd255, 8'd3, 8'd1, 8'd0};
    sel = 0;
    test_directed("mixed", 8, d, 0, 0, 1);
  endtask

  task automatic test_handshake();
    logic [7:0] d[8];
    sel = 0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) d[j] = 8'($urandom_range(255));
      test_directed("handshake", 8, d, 40, 50, 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[8];
    sel = 0;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 8; j++)
        d[j] = (b % 2 == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(255));
      test_directed("random", 8, d, 0, 0, 1);
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [7:0] d[8];
    int loaded = 0, cnt = 0, guard = 0;
    sel = 0;
    d = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    while (loaded < 8 && guard < 200) begin
      in_valid = 1;
      in_data  = d[loaded];
      if (o_in_ready) loaded++;
      step();
      guard++;
    end
    in_valid = 0;
    while (cnt < 10 && guard < 400) begin
      if (o_busy === 1'b1) cnt++;
      if (cnt < 10) step();
      guard++;
    end
    n_checks++;
    if (cnt != 10) begin
      n_errors++;
      $display("FAIL midreset_reach: got %0d sort cycles want 10", cnt);
    end
    reset = 1;
    step();
    reset = 0;
    n_checks++;
    if ({o_in_ready, o_busy, o_out_valid, o_passes} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL midreset_state: got ir=%b busy=%b ov=%b passes=%0d want 1 0 0 0",
               o_in_ready, o_busy, o_out_valid, o_passes);
    end
    d = '{8'd2, 8'd1, 8'd4, 8'd3, 8'd6, 8'd5, 8'd8, 8'd7};
    test_directed("after_reset", 8, d, 0, 0, 1);
  endtask

  task automatic test_n2();
    logic [7:0] d[8];
    sel = 1;
    d = '{8'd9, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    test_directed("n2_rev", 2, d, 0, 0, 1);
    d[0] = 8'd4; d[1] = 8'd9;
    test_directed("n2_fwd", 2, d, 0, 0, 1);
    d[0] = 8'd7; d[1] = 8'd7;
    test_directed("n2_eq", 2, d, 0, 0, 1);
    for (int b = 0; b < 3; b++) begin
      d[0] = 8'($urandom_range(255));
      d[1] = 8'($urandom_range(255));
      test_directed("n2_rand", 2, d, 30, 40, 0);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_reverse();
    test_mixed();
    test_handshake();
    test_back_to_back();
    test_reset_mid_sort();
    test_n2();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bubble_sort_seq.md
Name: bubble_sort_seq

Overview:
- Sequential sort engine. Accepts N unsigned W-bit words over a valid/ready input stream and stores them in an internal register array.
- Sorts the array in place in ascending order. Performs one compare-and-swap of adjacent elements per clock, in bubble-sort passes with early exit after the first pass that makes no swap.
- Returns the sorted words over a valid/ready output stream.
- Used where the combinational all-in-one sort is too large or too slow; trades latency for a single comparator.

Parameters:
- N, 8, number of elements per batch (N >= 2).
- W, 8, element width in bits, unsigned.
- PW, $clog2(N+1), width of the pass counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  block accepts an element this cycle.
- in_data  input  W  element to load.
- out_valid  output  1  out_data holds a valid sorted element.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  W  sorted element, smallest first.
- busy  output  1  high while sorting.
- passes  output  PW  number of passes executed for the current/last batch.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset; sampled on the rising edge of clk.
- Reset values:
  - state = LOAD; wr_idx = 0, rd_idx = 0, i = 0, swapped = 0, passes = 0.
  - Outputs: in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
  - The array contents are not reset and are never observable before being loaded.
- Reset asserted in any state, including mid-SORT or mid-DRAIN, abandons the batch and returns to LOAD next cycle. Partial batches are discarded.
- Handshake: a transfer occurs on a cycle where valid and ready are both 1. in_ready and out_valid depend on state only, never on in_valid or out_ready.
- LOAD:
  - in_ready = 1. On an input transfer, write mem[wr_idx] = in_data and increment wr_idx.
  - On the transfer with wr_idx == N-1: go to SORT, with i = 0, swapped = 0, passes = 0.
  - No transfer: hold all state.
- SORT:
  - busy = 1, in_ready = 0, out_valid = 0.
  - Each cycle, compare mem[i] and mem[i+1] (unsigned). If mem[i] > mem[i+1], swap them at the clock edge and set swapped.
  - Equal elements are never swapped, so the sort is stable.
  - If i < N-2: i increments.
  - If i == N-2 (end of pass): passes increments. Then:
    - if swapped was set or a swap occurs this cycle, start a new pass with i = 0, swapped = 0;
    - otherwise go to DRAIN with rd_idx = 0.
  - Each pass is N-1 cycles. A batch takes (number of passes) × (N-1) cycles in SORT.
  - Pass count ranges from 1 (input already sorted) to N (reverse-sorted input). passes never exceeds N.
- DRAIN:
  - out_valid = 1, out_data = mem[rd_idx], in_ready = 0, busy = 0.
  - On an output transfer rd_idx increments. On the transfer with rd_idx == N-1, go to LOAD with wr_idx = 0.
  - While out_ready = 0, out_data and out_valid hold stable.
- out_data = 0 outside DRAIN.
- passes holds its final value through DRAIN and the following LOAD. It clears on entry to SORT.
- The next batch's first element can be accepted on the cycle after the last output transfer. There is no overlap between LOAD and DRAIN.
- Index counters are $clog2(N) bits wide; they never wrap past N-1.

Test Plan:
- Reset, then load 1,2,3,4,5,6,7,8 with in_valid held high and out_ready = 1. Required: SORT lasts exactly 7 cycles with busy = 1; passes = 1; outputs 1..8 in order; 8 consecutive out_valid cycles.
- Load 8,7,6,5,4,3,2,1. Required: SORT lasts 56 cycles (8 passes × 7); passes = 8; outputs 1..8.
- Load 5,3,5,0,255,3,1,0 (W = 8). Required: outputs 0,0,1,3,3,5,5,255; unsigned compare, so 255 ends last; passes ≤ 8.
- Drain with out_ready toggled 1,0,0,1,... and input with in_valid gaps. Required: no lost or duplicated element; out_data stable while out_valid = 1 and out_ready = 0; in_ready = 0 throughout SORT and DRAIN.
- Assert reset for 1 cycle at the 10th SORT cycle of a reverse batch. Required: next cycle state = LOAD, in_ready = 1, busy = 0, passes = 0. A fresh batch 2,1,4,3,6,5,8,7 then yields 1..8 with passes = 2.
- N = 2 instance: load 9,4. Required: 1-cycle passes; passes = 2; outputs 4,9. Load 4,9: passes = 1.
